// File: rtl/markov_second_sampler.sv
// Second-order Markov next-note sampler.
// Scans a merged transition list {prev2, prev1, next, count} twice: the first
// pass totals the counts of entries matching the two-note context, the second
// walks a cumulative sum and picks the entry covering a scaled random target.
module markov_second_sampler #(
  parameter int NOTE_W  = 8,
  parameter int COUNT_W = 16,
  parameter int ADDR_W  = 10,
  parameter int RAND_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NOTE_W-1:0]   ctx_prev2,
  input  logic [NOTE_W-1:0]   ctx_prev1,
  input  logic [ADDR_W:0]     list_len,
  input  logic [RAND_W-1:0]   rand_val,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [NOTE_W-1:0]   mem_prev2,
  input  logic [NOTE_W-1:0]   mem_prev1,
  input  logic [NOTE_W-1:0]   mem_next,
  input  logic [COUNT_W-1:0]  mem_count,
  output logic [NOTE_W-1:0]   next_note,
  output logic                found,
  output logic                busy,
  output logic                done
);

  localparam int SUM_W  = COUNT_W + ADDR_W + 1;
  localparam int PROD_W = RAND_W + SUM_W;

  typedef enum logic [2:0] {IDLE, SUM, TARGET, SELECT, FINISH} state_t;

  state_t              state_q, state_d;
  logic [NOTE_W-1:0]   ctx2_q, ctx2_d;
  logic [NOTE_W-1:0]   ctx1_q, ctx1_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [RAND_W-1:0]   rand_q, rand_d;
  logic [SUM_W-1:0]    total_q, total_d;
  logic [SUM_W-1:0]    run_q, run_d;
  logic [SUM_W-1:0]    target_q, target_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ret_valid_q, ret_valid_d;
  logic [ADDR_W-1:0]   ret_addr_q, ret_addr_d;
  logic [NOTE_W-1:0]   next_note_q, next_note_d;
  logic                found_q, found_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                match;
  logic                last_issue;
  logic                last_ret;
  logic [SUM_W-1:0]    run_sum;
  logic [PROD_W-1:0]   product;

  // Helpers: entry match on the returned data, last-address detection for
  // issue and return sides, candidate cumulative sum and the scaled target.
  always_comb begin
    match      = ret_valid_q && (mem_prev2 == ctx2_q) && (mem_prev1 == ctx1_q);
    last_issue = rd_en_q && ({1'b0, addr_q} == (len_q - (ADDR_W+1)'(1)));
    last_ret   = ret_valid_q && ({1'b0, ret_addr_q} == (len_q - (ADDR_W+1)'(1)));
    run_sum    = run_q + SUM_W'(mem_count);
    product    = PROD_W'(rand_q) * PROD_W'(total_q);
  end

  // Next-state logic for the two-pass scan; all outputs are registered.
  always_comb begin
    state_d     = state_q;
    ctx2_d      = ctx2_q;
    ctx1_d      = ctx1_q;
    len_d       = len_q;
    rand_d      = rand_q;
    total_d     = total_q;
    run_d       = run_q;
    target_d    = target_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    ret_valid_d = rd_en_q;
    ret_addr_d  = addr_q;
    next_note_d = next_note_q;
    found_d     = found_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ctx2_d      = ctx_prev2;
          ctx1_d      = ctx_prev1;
          len_d       = list_len;
          rand_d      = rand_val;
          total_d     = '0;
          run_d       = '0;
          target_d    = '0;
          found_d     = 1'b0;
          next_note_d = '0;
          addr_d      = '0;
          if (list_len == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rd_en_d = 1'b0;
          end else begin
            state_d = SUM;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
          end
        end
      end

      SUM: begin
        if (rd_en_q) begin
          if (last_issue) rd_en_d = 1'b0;
          else            addr_d  = addr_q + 1'b1;
        end
        if (match) total_d = total_q + SUM_W'(mem_count);
        if (last_ret) state_d = TARGET;
      end

      TARGET: begin
        if (total_q == '0) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          target_d = SUM_W'(product >> RAND_W);
          run_d    = '0;
          addr_d   = '0;
          rd_en_d  = 1'b1;
          state_d  = SELECT;
        end
      end

      SELECT: begin
        if (rd_en_q) begin
          if (last_issue) rd_en_d = 1'b0;
          else            addr_d  = addr_q + 1'b1;
        end
        if (match && (run_sum > target_q)) begin
          next_note_d = mem_next;
          found_d     = 1'b1;
          rd_en_d     = 1'b0;
          state_d     = FINISH;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          if (match) run_d = run_sum;
          if (last_ret) begin
            rd_en_d = 1'b0;
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      FINISH: begin
        rd_en_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ctx2_q      <= '0;
      ctx1_q      <= '0;
      len_q       <= '0;
      rand_q      <= '0;
      total_q     <= '0;
      run_q       <= '0;
      target_q    <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_addr_q  <= '0;
      next_note_q <= '0;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx2_q      <= ctx2_d;
      ctx1_q      <= ctx1_d;
      len_q       <= len_d;
      rand_q      <= rand_d;
      total_q     <= total_d;
      run_q       <= run_d;
      target_q    <= target_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      ret_valid_q <= ret_valid_d;
      ret_addr_q  <= ret_addr_d;
      next_note_q <= next_note_d;
      found_q     <= found_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign next_note = next_note_q;
  assign found     = found_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_markov_second_sampler.sv
// Randomized self-checking bench for markov_second_sampler with a list-RAM
// model and a behavioural sampling reference.
module tb_markov_second_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ctx_prev2 = '0;
  logic [7:0]  ctx_prev1 = '0;
  logic [10:0] list_len = '0;
  logic [15:0] rand_val = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_prev2 = '0;
  logic [7:0]  mem_prev1 = '0;
  logic [7:0]  mem_next = '0;
  logic [15:0] mem_count = '0;
  logic [7:0]  next_note;
  logic        found;
  logic        busy;
  logic        done;

  logic [7:0]  tab_p2  [1024];
  logic [7:0]  tab_p1  [1024];
  logic [7:0]  tab_nx  [1024];
  logic [15:0] tab_cnt [1024];

  int checks = 0;
  int errors = 0;

  markov_second_sampler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ctx_prev2 (ctx_prev2),
    .ctx_prev1 (ctx_prev1),
    .list_len  (list_len),
    .rand_val  (rand_val),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_prev2 (mem_prev2),
    .mem_prev1 (mem_prev1),
    .mem_next  (mem_next),
    .mem_count (mem_count),
    .next_note (next_note),
    .found     (found),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // List RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_prev2 <= tab_p2[mem_addr];
      mem_prev1 <= tab_p1[mem_addr];
      mem_next  <= tab_nx[mem_addr];
      mem_count <= tab_cnt[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: weighted draw over matching entries, plus the expected
  // start-to-done latency in cycles (start cycle counted as cycle 0).
  task automatic model(input logic [7:0] p2, input logic [7:0] p1, input int len,
                       input logic [15:0] rnd, output int note, output int fnd,
                       output int lat);
    longint total = 0;
    longint tgt;
    longint run = 0;
    note = 0;
    fnd  = 0;
    for (int i = 0; i < len; i++)
      if (tab_p2[i] == p2 && tab_p1[i] == p1) total += longint'(tab_cnt[i]);
    if (len == 0) begin
      lat = 1;
    end else if (total == 0) begin
      lat = len + 3;
    end else begin
      tgt = (longint'(rnd) * total) / 65536;
      lat = -1;
      for (int i = 0; i < len; i++) begin
        if (tab_p2[i] == p2 && tab_p1[i] == p1) begin
          if (run + longint'(tab_cnt[i]) > tgt) begin
            note = int'(tab_nx[i]);
            fnd  = 1;
            lat  = len + i + 5;
            break;
          end
          run += longint'(tab_cnt[i]);
        end
      end
    end
  endtask

  task automatic setEntry(input int i, input int p2, input int p1, input int nx, input int cnt);
    tab_p2[i]  = 8'(p2);
    tab_p1[i]  = 8'(p1);
    tab_nx[i]  = 8'(nx);
    tab_cnt[i] = 16'(cnt);
  endtask

  task automatic loadPlanTable();
    setEntry(0, 60, 62, 64, 3);
    setEntry(1, 60, 62, 67, 1);
    setEntry(2, 55, 57, 59, 2);
  endtask

  // mode 0: plain request; mode 1: extra start while busy;
  // mode 2: start asserted in the done cycle.
  task automatic applyStimulus(input int p2, input int p1, input int len, input int rnd,
                               input int mode, input string tag);
    int expNote, expFound, expLat;
    int lat;
    int extra;
    int sawBusy;
    model(8'(p2), 8'(p1), len, 16'(rnd), expNote, expFound, expLat);
    @(negedge clk);
    ctx_prev2 = 8'(p2);
    ctx_prev1 = 8'(p1);
    list_len  = 11'(len);
    rand_val  = 16'(rnd);
    start     = 1'b1;
    lat = 0;
    sawBusy = 0;
    while (lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      start = 1'b0;
      if (mode == 1 && lat == 2) begin
        ctx_prev2 = 8'(p2 + 1);
        ctx_prev1 = 8'(p1 + 3);
        rand_val  = ~16'(rnd);
        list_len  = 11'(len + 1);
        start     = 1'b1;
      end
      if (busy) sawBusy = 1;
      if (done) break;
    end
    checkOutput({tag, "_done"}, 32'(done), 1);
    checkOutput({tag, "_note"}, 32'(next_note), expNote);
    checkOutput({tag, "_found"}, 32'(found), expFound);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 0);
    if (len > 0) checkOutput({tag, "_busy_seen"}, sawBusy, 1);
    if (mode == 2) start = 1'b1;
    extra = 0;
    repeat (2 * len + 8) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) extra++;
    end
    checkOutput({tag, "_extra_done"}, extra, 0);
    checkOutput({tag, "_note_hold"}, 32'(next_note), expNote);
    checkOutput({tag, "_found_hold"}, 32'(found), expFound);
  endtask

  initial begin
    int extra;
    for (int i = 0; i < 1024; i++) setEntry(i, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_note", 32'(next_note), 0);
    checkOutput("rst_found", 32'(found), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
    checkOutput("rst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    reset = 1'b1;

    loadPlanTable();
    applyStimulus(60, 62, 3, 16'h0000, 0, "plan_r0");
    applyStimulus(60, 62, 3, 16'hC000, 0, "plan_rC000");
    applyStimulus(60, 62, 3, 16'hBFFF, 0, "plan_rBFFF");
    applyStimulus(55, 57, 3, 16'hFFFF, 0, "plan_ctx55");
    applyStimulus(1, 2, 3, 16'h1234, 0, "plan_nomatch");
    applyStimulus(60, 62, 0, 16'h8000, 0, "len0");
    applyStimulus(60, 62, 3, 16'h4000, 1, "repulse");
    applyStimulus(60, 62, 3, 16'hC000, 2, "start_at_done");

    setEntry(3, 70, 71, 99, 0);
    applyStimulus(70, 71, 4, 16'h7777, 0, "zero_count");

    // Reset in the middle of the selection pass.
    applyStimulus(60, 62, 3, 16'hFFFF, 0, "pre_reset");
    @(negedge clk);
    ctx_prev2 = 8'd60;
    ctx_prev1 = 8'd62;
    list_len  = 11'd3;
    rand_val  = 16'hFFFF;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midsel_busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    checkOutput("midsel_rst_note", 32'(next_note), 0);
    checkOutput("midsel_rst_found", 32'(found), 0);
    checkOutput("midsel_rst_busy", 32'(busy), 0);
    checkOutput("midsel_rst_done", 32'(done), 0);
    checkOutput("midsel_rst_rd_en", 32'(mem_rd_en), 0);
    checkOutput("midsel_rst_addr", 32'(mem_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checkOutput("midsel_no_done", extra, 0);
    applyStimulus(60, 62, 3, 16'hC000, 0, "post_reset");

    // Randomized small tables with dense context collisions.
    for (int t = 0; t < 30; t++) begin
      int len;
      len = int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++)
        setEntry(i, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 5)));
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), len,
                    int'($urandom_range(0, 65535)), 0, $sformatf("rand%0d", t));
    end

    // Full-size table, single match at the last address.
    for (int i = 0; i < 1024; i++) setEntry(i, 1, 1, i & 255, 7);
    setEntry(1023, 9, 9, 123, 5);
    applyStimulus(9, 9, 1024, int'($urandom_range(0, 65535)), 0, "full_table");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/markov_second_sampler.md
Name: markov_second_sampler

Overview:
- Reads a merged second-order Markov transition list and draws the next note for a given two-note context.
- Each list entry is {prev2, prev1, next, count}. The block is the consumer of the merge engine's output list.
- Pass 1 sums the counts of the matching entries. Pass 2 walks a cumulative sum and selects the entry that covers a scaled random target.
- Sits between the list RAM and the note-generation sequencer.

Parameters:
- NOTE_W, 8, width of a note value
- COUNT_W, 16, width of an entry count
- ADDR_W, 10, list RAM address width
- RAND_W, 16, width of the random input

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- ctx_prev2  in  NOTE_W  context note n-2; latched on accepted start
- ctx_prev1  in  NOTE_W  context note n-1; latched on accepted start
- list_len  in  ADDR_W+1  number of valid entries, 0..2^ADDR_W; latched on start
- rand_val  in  RAND_W  random value; latched on start
- mem_rd_en  out  1  list RAM read strobe
- mem_addr  out  ADDR_W  list RAM address
- mem_prev2  in  NOTE_W  entry field
- mem_prev1  in  NOTE_W  entry field
- mem_next  in  NOTE_W  entry field
- mem_count  in  COUNT_W  entry field
- next_note  out  NOTE_W  selected note
- found  out  1  1 = context present with nonzero total
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-low, clk domain): state=IDLE. next_note=0, found=0, busy=0, done=0, mem_rd_en=0, mem_addr=0. All internal sums cleared. Reset mid-operation aborts immediately; no done pulse is issued.
- RAM timing: address presented with mem_rd_en in cycle n; entry fields valid in cycle n+1. Reads are pipelined, one per cycle.
- Internal widths:
  - SUM_W = COUNT_W+ADDR_W+1.
  - total and running sums are SUM_W bits and cannot overflow.
  - target = (rand_val * total) >> RAND_W, which guarantees target < total.
- A match means mem_prev2==ctx_prev2 and mem_prev1==ctx_prev1. Zero-count matching entries contribute nothing and are never selected.
- States:
  - IDLE: start=1 latches the inputs, sets busy=1, clears found/next_note. If list_len==0 → FINISH with found=0. Otherwise → SUM. start while busy is ignored.
  - SUM: issues addresses 0..list_len-1, one per cycle. Adds mem_count of each matching returned entry to total. After the last return → TARGET. Duration is list_len+1 cycles.
  - TARGET: one cycle. If total==0 → FINISH with found=0. Otherwise compute target, clear run=0 → SELECT.
  - SELECT: rescans from address 0. For each matching returned entry, if run+mem_count > target then next_note=mem_next, found=1, stop issuing reads, → FINISH. Otherwise run += mem_count. The first qualifying entry in address order wins. Pipelined reads issued past the winner are discarded.
  - FINISH: done=1 for exactly this cycle, busy=0 → IDLE. next_note and found hold until the next accepted start or reset.
- Worst-case latency from start to done: 2·list_len+4 cycles.
- A start pulse coincident with done (FINISH cycle) is ignored.

Test Plan:
- Table: A=(60,62,64,3), B=(60,62,67,1), C=(55,57,59,2), list_len=3. Context (60,62), rand_val=0x0000 → target 0, next_note=64, found=1, done pulses once.
- Same table, context (60,62):
  - rand_val=0xC000 → total 4, target 3, next_note=67.
  - rand_val=0xBFFF → target 2, next_note=64.
- Same table, context (55,57), rand_val=0xFFFF → next_note=59. Context (1,2) → found=0, next_note=0, done after list_len+3 cycles.
- list_len=0 → found=0, done within 2 cycles of start. Context matching only a zero-count entry → found=0.
- start re-pulsed while busy → ignored, and only one done is issued. Reset asserted during SELECT → outputs return to reset values immediately, no done. A fresh start afterwards completes correctly.
- Full table: list_len=1024, single matching entry at address 1023 with count 5, any rand_val → next_note equals that entry's next, latency exactly 2·1024+4 cycles.
